// File: rtl/local_history_bp_fwd.sv
// Local-history branch direction predictor: PC-hashed BHT selects a PHT counter.
// Adds a post-reset table sweep, D/E/M history forwarding and write-first table bypass.
module local_history_bp_fwd #(
  parameter int XLEN = 32,
  parameter int m    = 6,
  parameter int k    = 10,
  parameter int CTRW = 2,
  parameter int FWD  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            StallE,
  input  logic            StallM,
  input  logic            StallW,
  input  logic            FlushD,
  input  logic            FlushE,
  input  logic            FlushM,
  input  logic            FlushW,
  input  logic [XLEN-1:0] PCNextF,
  input  logic [XLEN-1:0] PCM,
  input  logic            BranchE,
  input  logic            BranchM,
  input  logic            PCSrcE,
  output logic [CTRW-1:0] BPDirD,
  output logic            BPDirWrongE,
  output logic            InitBusy
);

  localparam logic [CTRW-1:0] WNT     = {1'b0, {(CTRW-1){1'b1}}};
  localparam logic [CTRW-1:0] CTR_MAX = '1;

  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [k-1:0] ci;
  logic         run;

  logic [k-1:0]    bht [2**m];
  logic [CTRW-1:0] pht [2**k];

  logic [m-1:0]    idx_fetch, idx_f, idx_d, idx_e, idx_m, idx_w;
  logic [k-1:0]    lhr_fetch, lhr_f, lhr_d, lhr_e, lhr_m, lhr_w;
  logic [CTRW-1:0] ctr_d, ctr_e, ctr_m, new_ctr_m, new_ctr_w, pht_rd;
  logic            vld_d, pcsrc_m, pcsrc_w, branch_w, we;
  logic [k-1:0]    bht_wd;

  // The index only needs PC[m+1:1]; PCM adds nothing beyond the pipelined IdxM.
  logic unused_pc;
  assign unused_pc = ^{PCM, PCNextF[XLEN-1:m+2], PCNextF[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ci    <= '0;
    end else begin
      state <= state_n;
      if (state == CLEAR) ci <= ci + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    if (state == CLEAR && ci == '1) state_n = RUN;
  end

  assign run      = (state == RUN);
  assign InitBusy = ~run;

  assign idx_fetch = {PCNextF[m+1] ^ PCNextF[1], PCNextF[m:2]};
  assign we        = branch_w & ~StallW & ~FlushW & run;
  assign bht_wd    = {pcsrc_w, lhr_w[k-1:1]};

  // Later assignments win: M > E > D > W bypass > table read.
  always_comb begin
    lhr_fetch = bht[idx_fetch];
    if (we && idx_w == idx_fetch) lhr_fetch = bht_wd;
    if (FWD != 0) begin
      if (vld_d && idx_d == idx_fetch)   lhr_fetch = {ctr_d[CTRW-1], lhr_d[k-1:1]};
      if (BranchE && idx_e == idx_fetch) lhr_fetch = {ctr_e[CTRW-1], lhr_e[k-1:1]};
      if (BranchM && idx_m == idx_fetch) lhr_fetch = {pcsrc_m, lhr_m[k-1:1]};
    end
    if (!run) lhr_fetch = '0;
  end

  assign pht_rd = (we && lhr_w == lhr_f) ? new_ctr_w : pht[lhr_f];

  always_ff @(posedge clk) begin
    if (!run) begin
      pht[ci]        <= WNT;
      bht[ci[m-1:0]] <= '0;
    end else if (we) begin
      pht[lhr_w] <= new_ctr_w;
      bht[idx_w] <= bht_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_f <= '0; lhr_f <= '0;
    end else if (!StallF) begin
      idx_f <= idx_fetch; lhr_f <= lhr_fetch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      vld_d <= 1'b0; idx_d <= '0; lhr_d <= '0; ctr_d <= '0;
    end else if (!StallD) begin
      vld_d <= 1'b1; idx_d <= idx_f; lhr_d <= lhr_f; ctr_d <= run ? pht_rd : WNT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      idx_e <= '0; lhr_e <= '0; ctr_e <= '0;
    end else if (!StallE) begin
      idx_e <= idx_d; lhr_e <= lhr_d; ctr_e <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || FlushM) begin
      idx_m <= '0; lhr_m <= '0; ctr_m <= '0; pcsrc_m <= 1'b0;
    end else if (!StallM) begin
      idx_m <= idx_e; lhr_m <= lhr_e; ctr_m <= ctr_e; pcsrc_m <= PCSrcE;
    end
  end

  always_comb begin
    new_ctr_m = ctr_m;
    if (pcsrc_m && ctr_m != CTR_MAX)   new_ctr_m = ctr_m + 1'b1;
    else if (!pcsrc_m && ctr_m != '0) new_ctr_m = ctr_m - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || FlushW) begin
      idx_w <= '0; lhr_w <= '0; new_ctr_w <= '0; pcsrc_w <= 1'b0; branch_w <= 1'b0;
    end else if (!StallW) begin
      idx_w <= idx_m; lhr_w <= lhr_m; new_ctr_w <= new_ctr_m; pcsrc_w <= pcsrc_m;
      branch_w <= BranchM & run;
    end
  end

  assign BPDirD      = run ? ctr_d : WNT;
  assign BPDirWrongE = run & BranchE & (PCSrcE != ctr_e[CTRW-1]);

endmodule
